// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the byte-wide RAM port arbiter: access-size codes,
//   FSM state encoding, owner identifiers, common constants and small byte
//   lane helpers used when serialising stores and assembling loads.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Access size codes as presented on mem_size (3 is treated as a word).
  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  // Owner of the current grant.
  localparam logic OwnerIf  = 1'b0;
  localparam logic OwnerMem = 1'b1;

  localparam logic [31:0] ZeroWord = 32'd0;

  // Number of byte cycles for a MEM access size.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SizeByte: n = 3'd1;
      SizeHalf: n = 3'd2;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

  // Select byte lane idx of a word.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Return w with byte lane idx replaced by b.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one byte-wide synchronous RAM port between instruction fetch (IF)
//   and the MEM stage. One requester is granted at a time (MEM wins a tie) and
//   a 1/2/4-byte access is sequenced as back-to-back byte cycles. Load data is
//   assembled little-endian, zero-extended, and returned with a one-cycle done
//   pulse to the owner.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   if_req/if_addr       IF word-read request and byte address
//   if_data/if_done      fetched word (held) and completion pulse
//   mem_req/mem_we       MEM request, 1 = store
//   mem_size             0 byte, 1 half, 2/3 word
//   mem_addr/mem_wdata   MEM byte address and store data (low byte first)
//   mem_rdata/mem_done   load data (held) and completion pulse
//   ram_addr/ram_we      RAM byte address and write strobe
//   ram_wdata/ram_rdata  RAM write byte and read byte (one cycle after address)
//   busy_o               high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              busy_o
);

  state_e            state_r;
  logic [2:0]        cnt_r;      // byte index of the current BUSY cycle
  logic [2:0]        nbytes_r;   // 1, 2 or 4
  logic [ADDR_W-1:0] base_r;
  logic              we_r;
  logic [31:0]       wdata_r;
  logic              owner_r;
  logic [31:0]       asm_r;      // load bytes captured so far

  logic [2:0]        cnt_inc_s;
  logic              last_byte_s;
  logic [1:0]        idx_prev_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [7:0]        next_wbyte_s;

  // Helpers for the next byte cycle. The RAM-side outputs are registered, so
  // each BUSY edge prepares the address/data for the following cnt value.
  always_comb begin
    cnt_inc_s    = cnt_r + 3'd1;
    last_byte_s  = (cnt_r == (nbytes_r - 3'd1));
    // Read data arriving at cnt belongs to byte cnt-1 (cnt == 4 wraps to lane 3).
    idx_prev_s   = cnt_r[1:0] - 2'd1;
    next_addr_s  = base_r + ADDR_W'(cnt_inc_s);
    next_wbyte_s = pick_byte(wdata_r, cnt_inc_s[1:0]);
  end

  // Arbiter FSM with registered RAM-side, done, data and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= StIdle;
      cnt_r     <= 3'd0;
      nbytes_r  <= 3'd0;
      base_r    <= {ADDR_W{1'b0}};
      we_r      <= Disable;
      wdata_r   <= ZeroWord;
      owner_r   <= OwnerIf;
      asm_r     <= ZeroWord;
      if_data   <= ZeroWord;
      if_done   <= Disable;
      mem_rdata <= ZeroWord;
      mem_done  <= Disable;
      ram_addr  <= {ADDR_W{1'b0}};
      ram_we    <= Disable;
      ram_wdata <= 8'd0;
      busy_o    <= Disable;
    end else begin
      case (state_r)
        StIdle: begin
          if_done  <= Disable;
          mem_done <= Disable;
          cnt_r    <= 3'd0;
          asm_r    <= ZeroWord;
          if (mem_req) begin
            // MEM has priority; a simultaneous IF request stays pending.
            state_r   <= StBusy;
            owner_r   <= OwnerMem;
            base_r    <= mem_addr;
            we_r      <= mem_we;
            nbytes_r  <= size_to_bytes(mem_size);
            wdata_r   <= mem_wdata;
            ram_addr  <= mem_addr;
            ram_we    <= mem_we;
            ram_wdata <= mem_wdata[7:0];
            busy_o    <= Enable;
          end else if (if_req) begin
            state_r   <= StBusy;
            owner_r   <= OwnerIf;
            base_r    <= if_addr;
            we_r      <= Disable;
            nbytes_r  <= 3'd4;
            wdata_r   <= ZeroWord;
            ram_addr  <= if_addr;
            ram_we    <= Disable;
            ram_wdata <= 8'd0;
            busy_o    <= Enable;
          end else begin
            ram_addr  <= {ADDR_W{1'b0}};
            ram_we    <= Disable;
            ram_wdata <= 8'd0;
            busy_o    <= Disable;
          end
        end

        StBusy: begin
          if (we_r) begin
            if (last_byte_s) begin
              // Final byte strobed this cycle; finish without a trailing cycle.
              state_r   <= StDone;
              ram_addr  <= {ADDR_W{1'b0}};
              ram_we    <= Disable;
              ram_wdata <= 8'd0;
              if_done   <= (owner_r == OwnerIf);
              mem_done  <= (owner_r == OwnerMem);
            end else begin
              cnt_r     <= cnt_inc_s;
              ram_addr  <= next_addr_s;
              ram_we    <= Enable;
              ram_wdata <= next_wbyte_s;
            end
          end else if (cnt_r == nbytes_r) begin
            // Trailing cycle: last read byte arrives with no address driven.
            state_r <= StDone;
            if (owner_r == OwnerMem) begin
              mem_rdata <= put_byte(asm_r, idx_prev_s, ram_rdata);
              mem_done  <= Enable;
            end else begin
              if_data <= put_byte(asm_r, idx_prev_s, ram_rdata);
              if_done <= Enable;
            end
          end else begin
            cnt_r <= cnt_inc_s;
            if (cnt_r != 3'd0) begin
              asm_r <= put_byte(asm_r, idx_prev_s, ram_rdata);
            end else begin
              asm_r <= asm_r;
            end
            if (last_byte_s) begin
              ram_addr  <= {ADDR_W{1'b0}};
              ram_we    <= Disable;
              ram_wdata <= 8'd0;
            end else begin
              ram_addr  <= next_addr_s;
              ram_we    <= we_r;
              ram_wdata <= next_wbyte_s;
            end
          end
        end

        StDone: begin
          state_r   <= StIdle;
          if_done   <= Disable;
          mem_done  <= Disable;
          ram_addr  <= {ADDR_W{1'b0}};
          ram_we    <= Disable;
          ram_wdata <= 8'd0;
          busy_o    <= Disable;
        end

        default: begin
          state_r   <= StIdle;
          cnt_r     <= 3'd0;
          if_done   <= Disable;
          mem_done  <= Disable;
          ram_addr  <= {ADDR_W{1'b0}};
          ram_we    <= Disable;
          ram_wdata <= 8'd0;
          busy_o    <= Disable;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios plus randomized IF/MEM traffic against a transaction
//   level model: each grant is turned into the expected per-cycle RAM outputs,
//   done pulse and returned data from the request fields alone.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'd0;
  logic        busy_o;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- RAM environment (sync read, byte write) ----------------
  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h05;
      32'h0000_0102: return 8'h10;
      32'h0000_0103: return 8'h00;
      32'h0000_0010: return 8'h34;
      32'h0000_0011: return 8'h12;
      32'hFFFF_FFFE: return 8'h11;
      32'hFFFF_FFFF: return 8'h22;
      32'h0000_0000: return 8'h33;
      32'h0000_0001: return 8'h44;
      default:       return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return dflt(a);
  endfunction

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] = ram_wdata;
    ram_rdata <= rd(ram_addr);
  end

  int we_cnt = 0;
  int memdone_cnt = 0;
  always @(posedge clk) begin
    if (ram_we) we_cnt <= we_cnt + 1;
    if (mem_done) memdone_cnt <= memdone_cnt + 1;
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit          run_chk = 1'b0;
  bit          in_txn = 1'b0;
  int          g;
  bit          t_mem, t_we;
  int          t_n;
  logic [31:0] t_base, t_wdata;
  logic [31:0] exp_if = 32'd0, exp_mem = 32'd0;

  always @(negedge clk) begin
    int k, d;
    logic [31:0] ea, ewd, v;
    logic ewe, ebusy, eifd, ememd;
    if (run_chk) begin
      k = 0; d = 0; ea = 32'd0; ewd = 32'd0; ewe = 1'b0;
      ebusy = 1'b0; eifd = 1'b0; ememd = 1'b0;
      if (in_txn) begin
        k = cyc - g;
        d = t_we ? t_n + 1 : t_n + 2;
        ebusy = 1'b1;
        if (k >= 1 && k <= t_n) begin
          ea  = t_base + 32'(k - 1);
          ewe = t_we;
          ewd = (t_wdata >> (8 * (k - 1))) & 32'hFF;
        end
        if (k == d) begin
          if (t_mem) ememd = 1'b1; else eifd = 1'b1;
          if (!t_we) begin
            v = 32'd0;
            for (int i = 0; i < t_n; i++) v |= 32'(rd(t_base + 32'(i))) << (8 * i);
            if (t_mem) exp_mem = v; else exp_if = v;
          end
        end
      end
      chk("ram_addr",  ram_addr, ea);
      chk("ram_we",    {31'd0, ram_we}, {31'd0, ewe});
      chk("ram_wdata", {24'd0, ram_wdata}, ewd);
      chk("busy_o",    {31'd0, busy_o}, {31'd0, ebusy});
      chk("if_done",   {31'd0, if_done}, {31'd0, eifd});
      chk("mem_done",  {31'd0, mem_done}, {31'd0, ememd});
      chk("if_data",   if_data, exp_if);
      chk("mem_rdata", mem_rdata, exp_mem);
      if (in_txn && k == d) begin
        in_txn = 1'b0;
      end else if (!in_txn && !rst) begin
        if (mem_req) begin
          in_txn = 1'b1; g = cyc; t_mem = 1'b1; t_we = mem_we;
          t_n = (mem_size == 2'd0) ? 1 : (mem_size == 2'd1) ? 2 : 4;
          t_base = mem_addr; t_wdata = mem_wdata;
        end else if (if_req) begin
          in_txn = 1'b1; g = cyc; t_mem = 1'b0; t_we = 1'b0;
          t_n = 4; t_base = if_addr; t_wdata = 32'd0;
        end
      end
      if (rst) begin
        in_txn = 1'b0; exp_if = 32'd0; exp_mem = 32'd0;
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic if_txn(input logic [31:0] a, output int lat, output logic [31:0] data);
    int start;
    bit got;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a; start = cyc;
    got = 1'b0; lat = -1; data = 32'd0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (if_done) begin got = 1'b1; lat = cyc - start; data = if_data; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL if_timeout: got no if_done expected one within 60 cycles");
    end
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = $urandom;
  endtask

  task automatic mem_txn(input logic we, input logic [1:0] size, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] data);
    int start;
    bit got;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = a; mem_wdata = wd; start = cyc;
    got = 1'b0; lat = -1; data = 32'd0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (mem_done) begin got = 1'b1; lat = cyc - start; data = mem_rdata; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL mem_timeout: got no mem_done expected one within 60 cycles");
    end
    @(posedge clk); #1;
    mem_req = 1'b0; mem_we = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      1:       return $urandom;
      default: return 32'h40 + 32'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic if_driver(input int n);
    int lat;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      if_txn(rand_addr(), lat, d);
    end
  endtask

  task automatic mem_driver(input int n);
    int lat;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      mem_txn(1'($urandom), 2'($urandom_range(0, 3)), rand_addr(), $urandom, lat, d);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat_a, lat_b, g5, w0, md0;
    logic [31:0] d_a, d_b;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    @(posedge clk); #1 run_chk = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);

    // IF word read at 0x100.
    if_txn(32'h100, lat_a, d_a);
    chk("if_lat", 32'(lat_a), 32'd6);
    chk("if_word", d_a, 32'h0010_0513);

    // MEM byte store.
    w0 = we_cnt;
    mem_txn(1'b1, 2'd0, 32'h2003, 32'h1234_56AB, lat_b, d_b);
    chk("stb_lat", 32'(lat_b), 32'd2);
    chk("stb_we_cycles", 32'(we_cnt - w0), 32'd1);
    chk("stb_ram", {24'd0, rd(32'h2003)}, 32'h0000_00AB);

    // Simultaneous requests: MEM half load first, IF follows.
    fork
      if_txn(32'h100, lat_a, d_a);
      mem_txn(1'b0, 2'd1, 32'h10, 32'h0, lat_b, d_b);
    join
    chk("tie_mem_data", d_b, 32'h0000_1234);
    chk("tie_mem_lat", 32'(lat_b), 32'd4);
    chk("tie_if_lat", 32'(lat_a), 32'd11);
    chk("tie_if_data", d_a, 32'h0010_0513);

    // Address wrap.
    if_txn(32'hFFFF_FFFE, lat_a, d_a);
    chk("wrap_data", d_a, 32'h4433_2211);
    chk("wrap_lat", 32'(lat_a), 32'd6);

    // Reset in the middle of a word store.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h3000;
    mem_wdata = 32'hDEAD_BEEF; g5 = cyc;
    md0 = memdone_cnt;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_cycle", 32'(cyc - g5), 32'd3);
    chk("mrst_we", {31'd0, ram_we}, 32'd0);
    chk("mrst_busy", {31'd0, busy_o}, 32'd0);
    chk("mrst_mem_rdata", mem_rdata, 32'd0);
    chk("mrst_if_data", if_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mrst_no_done", 32'(memdone_cnt - md0), 32'd0);
    chk("mrst_byte0", {24'd0, rd(32'h3000)}, 32'h0000_00EF);
    chk("mrst_byte1", {24'd0, rd(32'h3001)}, 32'h0000_00BE);
    chk("mrst_byte2", {24'd0, rd(32'h3002)}, {24'd0, dflt(32'h3002)});

    // Randomized concurrent traffic.
    fork
      if_driver(40);
      mem_driver(40);
    join
    repeat (4) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
